// File: rtl/fft_pkg.sv
// Shared FFT datapath types, lane constants and the lane-order selector.
// FFT_P2S_BITREV_LANE_EN selects bit-reversed lane emission order in lane_sel().
package fft_pkg;

  localparam int unsigned LANES      = 4;
  localparam int unsigned LANE_IDX_W = 2;
  localparam int unsigned DATA_W_DEF = 32;

  typedef struct packed {
    logic [DATA_W_DEF/2-1:0] re;
    logic [DATA_W_DEF/2-1:0] im;
  } cplx_t;

  typedef enum logic {
    P2S_EMPTY = 1'b0,
    P2S_SHIFT = 1'b1
  } p2s_state_e;

  // Maps the serial lane position to the physical lane of the buffered word.
  function automatic logic [LANE_IDX_W-1:0] lane_sel(input logic [LANE_IDX_W-1:0] idx);
`ifdef FFT_P2S_BITREV_LANE_EN
    return {idx[0], idx[1]};
`else
    return idx;
`endif
  endfunction

endpackage

// File: rtl/fft_p2s_unloader.sv
// 4-lane to serial unloader for the FFT output, with frame-last tracking.
// FFT_P2S_BITREV_LANE_EN: emit lanes in order 0,2,1,3 instead of 0,1,2,3.
module fft_p2s_unloader
  import fft_pkg::*;
#(
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned FRAME_LEN = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*DATA_W-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_W-1:0]       out_data,
  output logic                    out_last
);

  localparam int unsigned CNT_W = $clog2(FRAME_LEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);
  localparam logic [LANE_IDX_W-1:0] LANE_LAST = LANE_IDX_W'(LANES - 1);

  if ((FRAME_LEN % LANES) != 0 || FRAME_LEN < LANES) begin : g_bad_frame_len
    $error("fft_p2s_unloader: FRAME_LEN must be a multiple of 4 and >= 4");
  end

  p2s_state_e                      state_q, state_d;
  logic [LANES-1:0][DATA_W-1:0]    data_q, data_d;
  logic [LANE_IDX_W-1:0]           lane_idx_q, lane_idx_d;
  logic [CNT_W-1:0]                cnt_q, cnt_d;

  logic full;
  logic in_hs;
  logic out_hs;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= P2S_EMPTY;
      data_q     <= '0;
      lane_idx_q <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      lane_idx_q <= lane_idx_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    full       = (state_q == P2S_SHIFT);
    // Reloading on the last-lane handshake keeps a word every 4 cycles with no bubble.
    in_ready   = !flush && (!full || (out_ready && lane_idx_q == LANE_LAST));
    in_hs      = in_valid && in_ready;
    out_hs     = full && out_ready;

    state_d    = state_q;
    data_d     = data_q;
    lane_idx_d = lane_idx_q;
    cnt_d      = cnt_q;

    if (flush) begin
      state_d    = P2S_EMPTY;
      lane_idx_d = '0;
      cnt_d      = '0;
    end else begin
      if (out_hs) begin
        lane_idx_d = lane_idx_q + LANE_IDX_W'(1);
        cnt_d      = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
        if (lane_idx_q == LANE_LAST) begin
          state_d = P2S_EMPTY;
        end
      end
      if (in_hs) begin
        data_d     = in_data;
        state_d    = P2S_SHIFT;
        lane_idx_d = '0;
      end
    end
  end

  assign out_valid = full;
  assign out_data  = data_q[lane_sel(lane_idx_q)];
  assign out_last  = full && (cnt_q == CNT_LAST);

endmodule

// File: doc/fft_p2s_unloader.md
Name: fft_p2s_unloader

Overview:
- Output-side unloader for the 4-parallel FFT datapath.
- The FFT core presents 4 lanes per cycle; this block buffers one 4-lane word and serialises it to 1 sample/cycle using valid/ready handshakes on both sides.
- It tracks the position within the frame and flags the last sample of each FFT frame.
- It is the counterpart of the input serial-to-parallel loader and sits between the FFT core output and the downstream consumer.

Parameters:
- DATA_W, 32, width of one complex sample (re in [DATA_W-1:DATA_W/2], im in [DATA_W/2-1:0]).
- FRAME_LEN, 16, samples per FFT frame. Must be a multiple of 4 and >= 4; elaboration error otherwise.

Ports:
- clk  in  1  single clock, all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous clear of buffer and frame position.
- in_valid  in  1  4-lane word available from FFT core.
- in_ready  out  1  block accepts word this cycle.
- in_data  in  4*DATA_W  lane k at [k*DATA_W +: DATA_W].
- out_valid  out  1  serial sample valid.
- out_ready  in  1  consumer accepts sample.
- out_data  out  DATA_W  serial sample.
- out_last  out  1  high with the final sample of a frame.

Behaviour:
- Internal state:
  - buf: 4 x DATA_W register.
  - full flag.
  - lane_idx: 2 bits.
  - samp_cnt: clog2(FRAME_LEN) bits.
- Reset (async, rst=1):
  - full=0, lane_idx=0, samp_cnt=0, buf=0.
  - Outputs: out_valid=0, out_data=0, out_last=0, in_ready=1.
  - Reset mid-word or mid-frame discards buffered data. There is no partial-frame recovery.
- States: EMPTY (full=0) and SHIFT (full=1).
- Output signals:
  - out_valid = full.
  - out_data = buf[lane_idx] (mux of registers, no extra latency).
  - out_last = full && samp_cnt==FRAME_LEN-1.
- in_ready = !full || (out_ready && lane_idx==3). This is a combinational path from out_ready and is intended; it gives full throughput of 1 word per 4 cycles.
- Input handshake: in_valid && in_ready loads buf, sets full=1 and lane_idx=0.
- Output handshake: out_valid && out_ready advances lane_idx and samp_cnt.
  - samp_cnt wraps FRAME_LEN-1 -> 0.
  - lane_idx wraps 3 -> 0.
- At lane_idx==3 with an output handshake:
  - If the input handshake occurs in the same cycle, buf reloads, full stays 1 and there is no bubble.
  - Otherwise full=0.
- Latency: a word accepted at cycle t presents lane 0 at cycle t+1.
- Back-pressure: with out_ready=0, out_data, out_last and lane_idx hold stable. in_valid and in_data are ignored while in_ready=0.
- Flush:
  - Synchronous. It has priority over both handshakes in the same cycle.
  - Clears full, lane_idx and samp_cnt. buf contents are don't-care.
  - in_ready is forced 0 during the flush cycle.
- Upstream obligation: in_data must hold while in_valid=1 && in_ready=0.

Optional Feature:
- Macro: FFT_P2S_BITREV_LANE_EN.
- Defined: lanes are emitted in bit-reversed lane order 0,2,1,3. The physical lane is {lane_idx[0],lane_idx[1]}. This undoes the radix-2^2 lane permutation.
- Undefined: natural order 0,1,2,3.
- Handshake, counters and out_last are identical in both builds.

Decomposition:
- Shared package fft_pkg holds:
  - LANES=4.
  - LANE_IDX_W=2.
  - Default DATA_W.
  - A typedef for the packed complex sample, shared with the input loader.
- No sub-module is needed beyond the existing D_reg-style flops. The lane selector mux (with optional bit reversal) is a natural small function in fft_pkg, lane_sel(idx).

Test Plan:
- Reset then one word, in_data lanes = 0x11,0x22,0x33,0x44, out_ready=1 -> out_data 0x11,0x22,0x33,0x44 on cycles t+1..t+4. Bitrev build gives 0x11,0x33,0x22,0x44. out_valid then drops.
- Continuous in_valid and out_ready for 4 words, FRAME_LEN=16 -> 16 back-to-back samples with no bubble, and out_last high only on sample 15. in_ready pulses once every 4 cycles.
- out_ready toggling 1,0,0,1 mid-word -> out_data held stable while stalled, with no sample lost or duplicated. in_ready stays 0 until the final lane handshake.
- flush asserted at lane_idx=2 with in_valid=1 -> the next cycle has out_valid=0 and samp_cnt=0. The word presented during flush is not accepted. The next frame's out_last lands at its sample 15.
- rst pulsed asynchronously between clock edges mid-frame -> outputs clear immediately without waiting for clk, and in_ready=1. After release, the next frame's out_last lands at its sample 15.
- Two frames back-to-back -> samp_cnt wraps cleanly and out_last fires at samples 15 and 31 only.
